// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the 16-bit CPU control sequencer.
// Holds the opcode map, control-word bundle and sequencer states.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_MV    = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_CMP   = 5'b00011;
  localparam logic [4:0] OP_LD    = 5'b00100;
  localparam logic [4:0] OP_ST    = 5'b00101;
  localparam logic [4:0] OP_JR    = 5'b01000;
  localparam logic [4:0] OP_JZR   = 5'b01001;
  localparam logic [4:0] OP_JNR   = 5'b01010;
  localparam logic [4:0] OP_CALLR = 5'b01100;
  localparam logic [4:0] OP_MVI   = 5'b10000;
  localparam logic [4:0] OP_ADDI  = 5'b10001;
  localparam logic [4:0] OP_SUBI  = 5'b10010;
  localparam logic [4:0] OP_CMPI  = 5'b10011;
  localparam logic [4:0] OP_MVHI  = 5'b10110;
  localparam logic [4:0] OP_J     = 5'b11000;
  localparam logic [4:0] OP_JZ    = 5'b11001;
  localparam logic [4:0] OP_JN    = 5'b11010;
  localparam logic [4:0] OP_CALL  = 5'b11100;

  typedef enum logic [2:0] {
    WB_MEM   = 3'b000,
    WB_ALU   = 3'b001,
    WB_PC2   = 3'b010,
    WB_RY    = 3'b011,
    WB_IMM8  = 3'b100,
    WB_IMMHI = 3'b101
  } wb_src_t;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_Z      = 2'b01,
    BR_N      = 2'b10
  } br_cond_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LD_WAIT,
    S_LD_WB,
    S_ST_WR,
    S_HALT
  } ctrl_state_t;

  typedef struct packed {
    logic     alu_op;
    logic     alu_src;
    logic     b_src;
    logic     reg_write;
    logic     reg_dst;
    wb_src_t  wb_src;
    logic     mem_write;
    logic     mem_sel;
    logic     ext_sel;
    logic     nz_en;
    logic     pc_enable;
    logic     pc_src;
    logic     br_src;
    br_cond_t br_cond;
  } ctrl_word_t;

endpackage

// File: rtl/cpu_ctrl_seq_decode.sv
// Combinational opcode to control-word table.
// Load/store words are neutral; the sequencer drives their memory strobes.
module ctrl_decode_table
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]  i_opcode,
  output ctrl_word_t  o_cw,
  output logic        o_illegal
);

  always_comb begin
    o_cw        = '0;
    o_cw.pc_src = 1'b1;
    o_illegal   = 1'b0;
    case (i_opcode)
      OP_MV: begin
        o_cw.reg_write = 1'b1;
        o_cw.wb_src    = WB_RY;
      end
      OP_ADD, OP_SUB: begin
        o_cw.reg_write = 1'b1;
        o_cw.wb_src    = WB_ALU;
        o_cw.nz_en     = 1'b1;
        o_cw.alu_op    = (i_opcode == OP_SUB);
      end
      OP_CMP: begin
        o_cw.nz_en  = 1'b1;
        o_cw.alu_op = 1'b1;
      end
      OP_MVI, OP_MVHI: begin
        o_cw.reg_write = 1'b1;
        o_cw.alu_src   = 1'b1;
        o_cw.b_src     = 1'b1;
        o_cw.wb_src    = (i_opcode == OP_MVI) ? WB_IMM8 : WB_IMMHI;
      end
      OP_ADDI, OP_SUBI: begin
        o_cw.reg_write = 1'b1;
        o_cw.alu_src   = 1'b1;
        o_cw.b_src     = 1'b1;
        o_cw.wb_src    = WB_ALU;
        o_cw.nz_en     = 1'b1;
        o_cw.alu_op    = (i_opcode == OP_SUBI);
      end
      OP_CMPI: begin
        o_cw.alu_src = 1'b1;
        o_cw.b_src   = 1'b1;
        o_cw.nz_en   = 1'b1;
        o_cw.alu_op  = 1'b1;
      end
      OP_JR, OP_JZR, OP_JNR, OP_CALLR,
      OP_J, OP_JZ, OP_JN, OP_CALL: begin
        o_cw.pc_enable = 1'b1;
        o_cw.pc_src    = 1'b0;
        o_cw.br_src    = i_opcode[4];
        o_cw.ext_sel   = i_opcode[4];
        o_cw.br_cond   = br_cond_t'(i_opcode[1:0]);
        // call variants link pc+2 into R7
        if (i_opcode[2]) begin
          o_cw.reg_write = 1'b1;
          o_cw.reg_dst   = 1'b1;
          o_cw.wb_src    = WB_PC2;
        end
      end
      OP_LD, OP_ST: begin
        o_cw.pc_src = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multicycle control sequencer for the 16-bit CPU.
// Table decode in FETCH, wait-state sequencing for ld/st, sticky halt.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned LD_WAIT       = 1,
  parameter int unsigned ST_WAIT       = 1,
  parameter bit          USE_MEM_READY = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] opcode,
  input  logic       instr_valid,
  input  logic       mem_ready,
  input  logic       stall,
  output logic       alu_op,
  output logic       alu_src,
  output logic       b_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic [2:0] wb_src,
  output logic       mem_write,
  output logic       mem_sel,
  output logic       ext_sel,
  output logic       nz_en,
  output logic       pc_enable,
  output logic       pc_src,
  output logic       br_src,
  output logic [1:0] br_cond,
  output logic       fetch,
  output logic       busy,
  output logic       halted
);

  generate
    if (ST_WAIT < 1) begin : g_bad_st_wait
      $error("ST_WAIT must be at least 1");
    end
  endgenerate

  localparam int unsigned MAXW = (LD_WAIT > ST_WAIT) ? LD_WAIT : ST_WAIT;
  localparam int unsigned CW   = $clog2(MAXW + 1);
  localparam logic [CW-1:0] LD_LAST = CW'((LD_WAIT > 0) ? LD_WAIT - 1 : 0);
  localparam logic [CW-1:0] ST_LAST = CW'(ST_WAIT - 1);
  localparam bit LD_SKIP = (LD_WAIT == 0) && !USE_MEM_READY;

  ctrl_state_t   r_state;
  ctrl_state_t   w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  ctrl_word_t    w_dec;
  ctrl_word_t    w_cw;
  ctrl_word_t    w_out;
  logic          w_illegal;
  logic          w_fetch;
  logic          w_busy;
  logic          w_halted;

  ctrl_decode_table u_table (
    .i_opcode  (opcode),
    .o_cw      (w_dec),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_cw        = '0;
    w_cw.pc_src = 1'b1;
    w_fetch     = 1'b0;
    w_busy      = 1'b0;
    w_halted    = 1'b0;
    unique case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        if (!stall && instr_valid) begin
          w_cw      = w_dec;
          w_fetch   = 1'b1;
          w_cnt_nxt = '0;
          if (w_illegal)
            w_next = S_HALT;
          else if (opcode == OP_LD)
            w_next = LD_SKIP ? S_LD_WB : S_LD_WAIT;
          else if (opcode == OP_ST)
            w_next = S_ST_WR;
        end
      end
      S_LD_WAIT: begin
        w_cw.mem_sel = 1'b1;
        w_busy       = 1'b1;
        // a stalled cycle neither counts nor consumes mem_ready
        if (!stall) begin
          if (USE_MEM_READY) begin
            if (mem_ready) w_next = S_LD_WB;
          end else if (r_cnt == LD_LAST) begin
            w_next = S_LD_WB;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_LD_WB: begin
        w_busy      = 1'b1;
        w_cw.wb_src = WB_MEM;
        if (!stall) begin
          w_cw.reg_write = 1'b1;
          w_fetch        = 1'b1;
          w_next         = S_FETCH;
        end
      end
      S_ST_WR: begin
        w_busy = 1'b1;
        if (!stall) begin
          w_cw.mem_write = 1'b1;
          if (USE_MEM_READY) begin
            if (mem_ready) w_next = S_FETCH;
          end else if (r_cnt == ST_LAST) begin
            w_next = S_FETCH;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_HALT: begin
        w_busy   = 1'b1;
        w_halted = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // reset forces every output low without waiting for a clock
  assign w_out     = reset ? w_cw : '0;
  assign alu_op    = w_out.alu_op;
  assign alu_src   = w_out.alu_src;
  assign b_src     = w_out.b_src;
  assign reg_write = w_out.reg_write;
  assign reg_dst   = w_out.reg_dst;
  assign wb_src    = w_out.wb_src;
  assign mem_write = w_out.mem_write;
  assign mem_sel   = w_out.mem_sel;
  assign ext_sel   = w_out.ext_sel;
  assign nz_en     = w_out.nz_en;
  assign pc_enable = w_out.pc_enable;
  assign pc_src    = w_out.pc_src;
  assign br_src    = w_out.br_src;
  assign br_cond   = w_out.br_cond;
  assign fetch     = reset & w_fetch;
  assign busy      = reset & w_busy;
  assign halted    = reset & w_halted;

endmodule
